// File: rtl/bus_node_fifo_pkg.sv
// Shared types and constants for the bus node FIFO endpoint.
package bus_node_pkg;

  localparam int unsigned ID_W    = 8;
  localparam logic [7:0]  BCAST   = 8'hFF;
  localparam int unsigned PKT_MAX = 256;

  localparam int unsigned ERR_TXOV = 0;
  localparam int unsigned ERR_TXUN = 1;
  localparam int unsigned ERR_RXOV = 2;

  typedef logic [ID_W-1:0] node_id_t;

  // Caller zero-extends the packet to PKT_MAX and passes its real width.
  function automatic node_id_t dest_of(input logic [PKT_MAX-1:0] pkt, input int unsigned w);
    return node_id_t'(pkt >> (w - ID_W));
  endfunction

endpackage

// File: rtl/bus_node_fifo_if.sv
// Agent/bus-facing signal bundle of one bus node endpoint.
interface bus_node_fifo_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
);
  logic                     wr_en;
  logic [pckg_sz-1:0]       wr_data;
  logic                     tx_full;
  logic [$clog2(depth):0]   tx_count;
  logic                     pndng;
  logic                     pop;
  logic [pckg_sz-1:0]       D_pop;
  logic                     push;
  logic [pckg_sz-1:0]       D_push;
  logic                     rx_valid;
  logic [pckg_sz-1:0]       rx_data;
  logic                     rx_ready;
  logic [2:0]               err;

  modport master (
    output wr_en, wr_data, pop, push, D_push, rx_ready,
    input  tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, err
  );

  modport slave (
    input  wr_en, wr_data, pop, push, D_push, rx_ready,
    output tx_full, tx_count, pndng, D_pop, rx_valid, rx_data, err
  );
endinterface

// File: rtl/bus_node_fifo_sync.sv
// Synchronous first-word fall-through FIFO with wrap-bit pointers.
module node_sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [width-1:0]         wdata,
  input  logic                     rd,
  output logic [width-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  output logic                     unf
);
  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wr_ok, rd_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // A full FIFO is never empty, so a read frees the slot for a same-cycle write.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd);
  assign ovf   = wr && full && !rd;
  assign unf   = rd && empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_node_fifo.sv
// Bus node endpoint: TX/RX FIFO pair, RX destination filter, sticky error flags.
// Define ADDR_FILTER_EN to accept only packets addressed to id or broadcast.
module bus_node_fifo
  import bus_node_pkg::*;
#(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter node_id_t    id        = 8'd0,
  parameter node_id_t    broadcast = BCAST
) (
  input  logic            clk,
  input  logic            reset,
  bus_node_fifo_if.slave  bif
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic          tx_empty, tx_ovf, tx_unf;
  logic          rx_wr, rx_empty, rx_full, rx_ovf, rx_unf;
  logic [CW-1:0] rx_count;
  node_id_t      rx_dest;
  logic [2:0]    err_q, err_d;
  logic          unused_ok;

  assign rx_dest = dest_of(PKT_MAX'(bif.D_push), pckg_sz);

`ifdef ADDR_FILTER_EN
  assign rx_wr     = bif.push && (rx_dest == id || rx_dest == broadcast);
  assign unused_ok = ^{rx_count, rx_unf, rx_full};
`else
  assign rx_wr     = bif.push;
  assign unused_ok = ^{rx_count, rx_unf, rx_full, rx_dest, id, broadcast};
`endif

  node_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk   (clk),
    .reset (reset),
    .wr    (bif.wr_en),
    .wdata (bif.wr_data),
    .rd    (bif.pop),
    .rdata (bif.D_pop),
    .empty (tx_empty),
    .full  (bif.tx_full),
    .count (bif.tx_count),
    .ovf   (tx_ovf),
    .unf   (tx_unf)
  );

  node_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr),
    .wdata (bif.D_push),
    .rd    (bif.rx_ready),
    .rdata (bif.rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count),
    .ovf   (rx_ovf),
    .unf   (rx_unf)
  );

  assign bif.pndng    = !tx_empty;
  assign bif.rx_valid = !rx_empty;
  assign bif.err      = err_q;

  always_comb begin
    err_d = err_q;
    if (tx_ovf) err_d[ERR_TXOV] = 1'b1;
    if (tx_unf) err_d[ERR_TXUN] = 1'b1;
    if (rx_ovf) err_d[ERR_RXOV] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

endmodule

// File: tb/tb_bus_node_fifo.sv
// Randomized and directed bench for bus_node_fifo against a queue-based reference model.
module tb_bus_node_fifo;
  import bus_node_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned D     = 8;
  localparam logic [7:0]  MY_ID = 8'h03;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_node_fifo_if #(.pckg_sz(W), .depth(D)) bif();

  bus_node_fifo #(.pckg_sz(W), .depth(D), .id(MY_ID), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic [2:0]   err_m;
  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic rst_n, input logic wr, input logic [W-1:0] wd,
                       input logic pp, input logic ps, input logic [W-1:0] dp,
                       input logic rr);
    logic tx_full_m, rx_full_m, accept;
    logic [7:0] dst;
    reset        = rst_n;
    bif.wr_en    = wr;
    bif.wr_data  = wd;
    bif.pop      = pp;
    bif.push     = ps;
    bif.D_push   = dp;
    bif.rx_ready = rr;
    dst = dp[W-1 -: 8];
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      err_m = '0;
    end else begin
      tx_full_m = (txq.size() == D);
      if (pp && txq.size() == 0) err_m[1] = 1'b1;
      if (wr && tx_full_m && !pp) err_m[0] = 1'b1;
      if (pp && txq.size() > 0) void'(txq.pop_front());
      if (wr && (!tx_full_m || pp)) txq.push_back(wd);
`ifdef ADDR_FILTER_EN
      accept = ps && (dst == MY_ID || dst == 8'hFF);
`else
      accept = ps && (dst == dst);
`endif
      rx_full_m = (rxq.size() == D);
      if (accept && rx_full_m && !rr) err_m[2] = 1'b1;
      if (rr && rxq.size() > 0) void'(rxq.pop_front());
      if (accept && (!rx_full_m || rr)) rxq.push_back(dp);
    end
    @(posedge clk);
    #1;
    check_eq("pndng",    32'(bif.pndng),    32'(txq.size() > 0));
    check_eq("tx_full",  32'(bif.tx_full),  32'(txq.size() == D));
    check_eq("tx_count", 32'(bif.tx_count), txq.size());
    check_eq("D_pop",    32'(bif.D_pop),    txq.size() > 0 ? 32'(txq[0]) : 32'd0);
    check_eq("rx_valid", 32'(bif.rx_valid), 32'(rxq.size() > 0));
    check_eq("rx_data",  32'(bif.rx_data),  rxq.size() > 0 ? 32'(rxq[0]) : 32'd0);
    check_eq("err",      32'(bif.err),      32'(err_m));
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [7:0]   dst;
    reset = 1'b0;
    bif.wr_en = 1'b0; bif.wr_data = '0; bif.pop = 1'b0;
    bif.push = 1'b0;  bif.D_push = '0;  bif.rx_ready = 1'b0;

    do_reset();

    // Basic write/pop ordering and one-cycle visibility
    cycle(1'b1, 1'b1, 16'h0201, 1'b0, 1'b0, '0, 1'b0);
    check_eq("first_dpop", 32'(bif.D_pop), 32'h0201);
    cycle(1'b1, 1'b1, 16'h0302, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check_eq("second_dpop", 32'(bif.D_pop), 32'h0302);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // TX overflow then drain
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, W'(16'h1000 + i), 1'b0, 1'b0, '0, 1'b0);
    check_eq("txov_err", 32'(bif.err), 32'h1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Full with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, W'(16'h2000 + i), 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 16'h2ABC, 1'b1, 1'b0, '0, 1'b0);
    check_eq("full_wp_count", 32'(bif.tx_count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // RX address filtering
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h03AA, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h05BB, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'hFFCC, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // RX overflow, TX underflow
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, W'(16'h0340 + i), 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check_eq("rxov_txun_err", 32'(bif.err), 32'h6);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'h03EE, 1'b1);

    // Reset mid-burst discards contents
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, W'(16'h4000 + i), 1'b0, 1'b1, W'(16'h0300 + i), 1'b0);
    cycle(1'b1, 1'b1, 16'h4FFF, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 16'h4EEE, 1'b1, 1'b1, 16'h03DD, 1'b1);
    check_eq("rst_count", 32'(bif.tx_count), 32'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 2))
        0:       dst = MY_ID;
        1:       dst = 8'hFF;
        default: dst = 8'($urandom);
      endcase
      d = {dst, 8'($urandom)};
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 6, W'($urandom),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 6, d,
            $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
